dram_response_assembler: RTL and testbench

- Downstream of the DRAM request queue, on the scratchpad-load path (DRAM read to SRAM write).
- Collects the 64-bit DRAM read-response beats of one scratchpad row. A row is 8 beats; each beat carries four 16-bit elements.
- Reassembles the beats in element order, possibly out of order, and presents one full 32-element row to the SRAM write port with a valid/ready handshake.
- Counts accepted rows and flags completion of the scheduled transaction.

---
 rtl/scpad_pkg.sv | 39 +++
 rtl/row_assembly_buffer.sv | 56 +++++
 rtl/dram_response_assembler.sv | 175 +++++++++++++++++
 tb/tb_dram_response_assembler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/scpad_pkg.sv
// Shared scratchpad-load types: DRAM response beat, assembled SRAM row and the
// row-assembly FSM state encoding.
package scpad_pkg;

   localparam int BEATS_PER_ROW = 8;
   localparam int DRAM_BEAT_W   = 64;
   localparam int SCPAD_ELEM_W  = 16;
   localparam int DRAM_ID_W     = 8;
   localparam int SUB_ID_W      = $clog2(BEATS_PER_ROW);
   localparam int ROW_TAG_W     = DRAM_ID_W - SUB_ID_W;
   localparam int ROW_W         = BEATS_PER_ROW * DRAM_BEAT_W;
   localparam int ROW_CNT_W     = 8;

   typedef struct packed {
      logic                   valid;
      logic [DRAM_ID_W-1:0]   id;
      logic [DRAM_BEAT_W-1:0] rdata;
   } dram_rsp_t;

   typedef struct packed {
      logic [ROW_TAG_W-1:0] tag;
      logic [ROW_W-1:0]     data;
   } sram_row_t;

   typedef enum logic [1:0] {
      ASM_EMPTY   = 2'd0,
      ASM_FILLING = 2'd1,
      ASM_FULL    = 2'd2
   } asm_state_t;

   function automatic logic [SUB_ID_W-1:0] sub_id_of(input logic [DRAM_ID_W-1:0] id);
      return id[SUB_ID_W-1:0];
   endfunction

   function automatic logic [ROW_TAG_W-1:0] row_tag_of(input logic [DRAM_ID_W-1:0] id);
      return id[DRAM_ID_W-1:SUB_ID_W];
   endfunction

endpackage

// File: rtl/row_assembly_buffer.sv
// Beat slots of one scratchpad row plus an arrival bitmap; exposes the
// post-write contents so a completing beat can bypass straight to the output.
module row_assembly_buffer
   import scpad_pkg::*;
#(
   parameter int BEATS  = BEATS_PER_ROW,
   parameter int BEAT_W = DRAM_BEAT_W
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic                       wr_en,
   input  logic [$clog2(BEATS)-1:0]   wr_idx,
   input  logic [BEAT_W-1:0]          wr_data,
   input  logic                       clr,
   output logic                       bit_set,
   output logic                       full_next,
   output logic [BEATS*BEAT_W-1:0]    data,
   output logic [BEATS*BEAT_W-1:0]    data_next
);

   logic [BEATS-1:0]        bitmap_r;
   logic [BEATS-1:0]        bitmap_next_s;
   logic [BEATS*BEAT_W-1:0] data_r;
   logic [BEATS*BEAT_W-1:0] data_next_s;

   // contents as they would be after this cycle's write
   always_comb begin
      bitmap_next_s = bitmap_r;
      data_next_s   = data_r;
      if (wr_en) begin
         bitmap_next_s[wr_idx]                 = 1'b1;
         data_next_s[wr_idx*BEAT_W +: BEAT_W]  = wr_data;
      end else begin
         bitmap_next_s = bitmap_r;
      end
   end

   // clear drops only the bitmap; stale slots are rewritten before the next row completes
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         bitmap_r <= '0;
         data_r   <= '0;
      end else if (clr) begin
         bitmap_r <= '0;
      end else begin
         bitmap_r <= bitmap_next_s;
         data_r   <= data_next_s;
      end
   end

   assign bit_set   = bitmap_r[wr_idx];
   assign full_next = &bitmap_next_s;
   assign data      = data_r;
   assign data_next = data_next_s;

endmodule

// File: rtl/dram_response_assembler.sv
// Reassembles out-of-order DRAM read beats into full scratchpad rows and hands
// them to the SRAM write port; counts rows and flags end of transaction.
module dram_response_assembler
   import scpad_pkg::*;
#(
   parameter int BEATS     = BEATS_PER_ROW,
   parameter int BEAT_W    = DRAM_BEAT_W,
   parameter int ELEM_W    = SCPAD_ELEM_W,
   parameter int ID_W      = DRAM_ID_W,
   parameter int ROW_CNT_W = scpad_pkg::ROW_CNT_W
) (
   input  logic                                       clk,
   input  logic                                       n_rst,
   input  logic                                       dram_rsp_valid,
   input  logic [ID_W-1:0]                            dram_rsp_id,
   input  logic [BEAT_W-1:0]                          dram_rsp_rdata,
   output logic                                       dram_rsp_stall,
   output logic                                       sram_wr_valid,
   output logic [ID_W-$clog2(BEATS)-1:0]              sram_wr_tag,
   output logic [ELEM_W*((BEATS*BEAT_W)/ELEM_W)-1:0]  sram_wr_data,
   input  logic                                       sram_wr_ready,
   input  logic [ROW_CNT_W-1:0]                       cfg_last_row,
   output logic                                       txn_done,
   output logic                                       protocol_err
);

   localparam int SUB_W = $clog2(BEATS);
   localparam int TAG_W = ID_W - SUB_W;
   localparam int RW    = BEATS * BEAT_W;

   asm_state_t            state_r, next_state_s;
   dram_rsp_t             rsp_s;
   sram_row_t             out_r;
   logic [SUB_W-1:0]      sub_id_s;
   logic [TAG_W-1:0]      tag_s, tag_r, load_tag_s;
   logic [RW-1:0]         buf_data_s, buf_data_next_s, load_data_s;
   logic                  tag_hit_s, accept_s, complete_s, slot_free_s, hs_s;
   logic                  buf_wr_en_s, buf_clr_s, buf_bit_set_s, buf_full_next_s;
   logic                  load_out_s, err_s, out_valid_r, err_r;
   logic [ROW_CNT_W-1:0]  row_cnt_r;
   logic                  last_row_s;

   assign rsp_s       = '{valid: dram_rsp_valid, id: dram_rsp_id, rdata: dram_rsp_rdata};
   assign sub_id_s    = sub_id_of(rsp_s.id);
   assign tag_s       = row_tag_of(rsp_s.id);
   assign tag_hit_s   = (tag_s == tag_r);
   assign accept_s    = rsp_s.valid && ((state_r == ASM_EMPTY) ||
                                        ((state_r == ASM_FILLING) && tag_hit_s));
   assign complete_s  = accept_s && buf_full_next_s;
   assign slot_free_s = !out_valid_r || sram_wr_ready;
   assign hs_s        = out_valid_r && sram_wr_ready;

   row_assembly_buffer #(.BEATS(BEATS), .BEAT_W(BEAT_W)) u_buf (
      .clk       (clk),
      .n_rst     (n_rst),
      .wr_en     (buf_wr_en_s),
      .wr_idx    (sub_id_s),
      .wr_data   (rsp_s.rdata),
      .clr       (buf_clr_s),
      .bit_set   (buf_bit_set_s),
      .full_next (buf_full_next_s),
      .data      (buf_data_s),
      .data_next (buf_data_next_s)
   );

   // state register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r <= ASM_EMPTY;
      end else begin
         state_r <= next_state_s;
      end
   end

   // next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ASM_EMPTY, ASM_FILLING: begin
            if (complete_s) begin
               next_state_s = slot_free_s ? ASM_EMPTY : ASM_FULL;
            end else if (accept_s) begin
               next_state_s = ASM_FILLING;
            end else begin
               next_state_s = state_r;
            end
         end
         ASM_FULL: begin
            next_state_s = slot_free_s ? ASM_EMPTY : ASM_FULL;
         end
         default: next_state_s = ASM_EMPTY;
      endcase
   end

   // FSM outputs: buffer write/clear, output-register load source, error
   always_comb begin
      buf_wr_en_s = 1'b0;
      buf_clr_s   = 1'b0;
      load_out_s  = 1'b0;
      err_s       = 1'b0;
      load_tag_s  = tag_r;
      load_data_s = buf_data_s;
      case (state_r)
         ASM_EMPTY, ASM_FILLING: begin
            buf_wr_en_s = accept_s;
            err_s       = (state_r == ASM_FILLING) && rsp_s.valid &&
                          (!tag_hit_s || buf_bit_set_s);
            if (complete_s && slot_free_s) begin
               load_out_s  = 1'b1;
               buf_clr_s   = 1'b1;
               load_tag_s  = (state_r == ASM_EMPTY) ? tag_s : tag_r;
               load_data_s = buf_data_next_s;
            end else begin
               load_out_s  = 1'b0;
            end
         end
         ASM_FULL: begin
            err_s = rsp_s.valid;
            if (slot_free_s) begin
               load_out_s = 1'b1;
               buf_clr_s  = 1'b1;
            end else begin
               load_out_s = 1'b0;
            end
         end
         default: begin
            err_s = 1'b0;
         end
      endcase
   end

   // row tag latched by the first beat of a row
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         tag_r <= '0;
      end else if ((state_r == ASM_EMPTY) && accept_s) begin
         tag_r <= tag_s;
      end
   end

   // output register: a reload may coincide with the handshake
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         out_valid_r <= 1'b0;
         out_r       <= '0;
      end else if (load_out_s) begin
         out_valid_r <= 1'b1;
         out_r       <= '{tag: load_tag_s, data: load_data_s};
      end else if (sram_wr_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   // error pulse and row counter
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         err_r     <= 1'b0;
         row_cnt_r <= '0;
      end else begin
         err_r <= err_s;
         if (hs_s) begin
            row_cnt_r <= last_row_s ? '0 : row_cnt_r + {{(ROW_CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign last_row_s     = (row_cnt_r == cfg_last_row);
   assign txn_done       = hs_s && last_row_s;
   assign dram_rsp_stall = (state_r == ASM_FULL);
   assign sram_wr_valid  = out_valid_r;
   assign sram_wr_tag    = out_r.tag;
   assign sram_wr_data   = out_r.data;
   assign protocol_err   = err_r;

endmodule

// File: tb/tb_dram_response_assembler.sv
// Directed, table-driven bench for dram_response_assembler plus hand-written
// reset and transaction-end sequences.
module tb_dram_response_assembler;

   logic         clk = 1'b0;
   logic         n_rst;
   logic         dram_rsp_valid;
   logic [7:0]   dram_rsp_id;
   logic [63:0]  dram_rsp_rdata;
   logic         dram_rsp_stall;
   logic         sram_wr_valid;
   logic [4:0]   sram_wr_tag;
   logic [511:0] sram_wr_data;
   logic         sram_wr_ready;
   logic [7:0]   cfg_last_row;
   logic         txn_done;
   logic         protocol_err;

   int total = 0;
   int bad   = 0;

   dram_response_assembler dut (
      .clk            (clk),
      .n_rst          (n_rst),
      .dram_rsp_valid (dram_rsp_valid),
      .dram_rsp_id    (dram_rsp_id),
      .dram_rsp_rdata (dram_rsp_rdata),
      .dram_rsp_stall (dram_rsp_stall),
      .sram_wr_valid  (sram_wr_valid),
      .sram_wr_tag    (sram_wr_tag),
      .sram_wr_data   (sram_wr_data),
      .sram_wr_ready  (sram_wr_ready),
      .cfg_last_row   (cfg_last_row),
      .txn_done       (txn_done),
      .protocol_err   (protocol_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       vld;
      logic [4:0] tag;
      logic [2:0] sub;
      logic       rdy;
      logic       exp_wv;
      logic       exp_stall;
      logic       exp_err;
      logic [4:0] exp_tag;
   } vec_t;

   vec_t vecs[$];

   // element 4k+i of a row tagged t = {3'b0, t, i, 3'b0, k}
   function automatic logic [63:0] beat_word(input logic [4:0] tag, input logic [2:0] k);
      logic [63:0] w;
      for (int i = 0; i < 4; i++) w[16*i +: 16] = {3'b000, tag, 2'(i), 3'b000, k};
      return w;
   endfunction

   function automatic logic [511:0] exp_row(input logic [4:0] tag);
      logic [511:0] r;
      for (int e = 0; e < 32; e++) r[16*e +: 16] = {3'b000, tag, 2'(e % 4), 3'b000, 3'(e / 4)};
      return r;
   endfunction

   function automatic void add(input logic vld, input logic [4:0] tag, input logic [2:0] sub,
                               input logic rdy, input logic wv, input logic st,
                               input logic er, input logic [4:0] etag);
      vec_t v;
      v.vld = vld; v.tag = tag; v.sub = sub; v.rdy = rdy;
      v.exp_wv = wv; v.exp_stall = st; v.exp_err = er; v.exp_tag = etag;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [4:0] tag, input logic [2:0] sub);
      dram_rsp_valid = 1'b1;
      dram_rsp_id    = {tag, sub};
      dram_rsp_rdata = beat_word(tag, sub);
      tick();
      dram_rsp_valid = 1'b0;
   endtask

   task automatic fill_row(input logic [4:0] tag, input logic rdy, input string name);
      sram_wr_ready = rdy;
      for (int k = 0; k < 8; k++) send_beat(tag, 3'(k));
      check({name, "_valid"}, 512'(sram_wr_valid), 512'(1'b1));
      check({name, "_tag"}, 512'(sram_wr_tag), 512'(tag));
      check({name, "_data"}, sram_wr_data, exp_row(tag));
   endtask

   initial begin
      int order[8];
      order = '{7, 3, 0, 1, 6, 2, 5, 4};

      // in-order fill, tag 5
      for (int k = 0; k < 8; k++) add(1'b1, 5'd5, 3'(k), 1'b1, k == 7, 1'b0, 1'b0, 5'd5);
      add(1'b0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
      // out-of-order fill, tag 5
      for (int j = 0; j < 8; j++) add(1'b1, 5'd5, 3'(order[j]), 1'b1, j == 7, 1'b0, 1'b0, 5'd5);
      add(1'b0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
      // tag mismatch and duplicate beat while filling tag 3
      add(1'b1, 5'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
      add(1'b1, 5'd4, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
      add(1'b1, 5'd3, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
      add(1'b1, 5'd3, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
      add(1'b1, 5'd3, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
      for (int k = 3; k < 8; k++) add(1'b1, 5'd3, 3'(k), 1'b1, k == 7, 1'b0, 1'b0, 5'd3);
      add(1'b0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
      // backpressure: rows 1 and 2 with ready low
      for (int k = 0; k < 8; k++) add(1'b1, 5'd1, 3'(k), 1'b0, k == 7, 1'b0, 1'b0, 5'd1);
      for (int k = 0; k < 8; k++) add(1'b1, 5'd2, 3'(k), 1'b0, 1'b1, k == 7, 1'b0, 5'd1);
      add(1'b1, 5'd6, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1);
      add(1'b0, 5'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2);
      add(1'b0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);

      n_rst          = 1'b0;
      dram_rsp_valid = 1'b0;
      dram_rsp_id    = 8'd0;
      dram_rsp_rdata = 64'd0;
      sram_wr_ready  = 1'b0;
      cfg_last_row   = 8'd255;
      #2;
      check("rst_valid", 512'(sram_wr_valid), 512'(1'b0));
      check("rst_stall", 512'(dram_rsp_stall), 512'(1'b0));
      check("rst_err", 512'(protocol_err), 512'(1'b0));
      check("rst_txn_done", 512'(txn_done), 512'(1'b0));
      check("rst_tag", 512'(sram_wr_tag), 512'(5'd0));
      check("rst_data", sram_wr_data, 512'd0);
      tick();
      n_rst = 1'b1;

      for (int n = 0; n < vecs.size(); n++) begin
         dram_rsp_valid = vecs[n].vld;
         dram_rsp_id    = {vecs[n].tag, vecs[n].sub};
         dram_rsp_rdata = beat_word(vecs[n].tag, vecs[n].sub);
         sram_wr_ready  = vecs[n].rdy;
         tick();
         check($sformatf("v%0d_valid", n), 512'(sram_wr_valid), 512'(vecs[n].exp_wv));
         check($sformatf("v%0d_stall", n), 512'(dram_rsp_stall), 512'(vecs[n].exp_stall));
         check($sformatf("v%0d_err", n), 512'(protocol_err), 512'(vecs[n].exp_err));
         if (vecs[n].exp_wv) begin
            check($sformatf("v%0d_tag", n), 512'(sram_wr_tag), 512'(vecs[n].exp_tag));
            check($sformatf("v%0d_data", n), sram_wr_data, exp_row(vecs[n].exp_tag));
         end
      end
      dram_rsp_valid = 1'b0;

      // reset mid-fill: a presented row plus half of the next one are discarded
      fill_row(5'd10, 1'b0, "pre_rst_row");
      for (int k = 4; k < 8; k++) send_beat(5'd9, 3'(k));
      #2;
      n_rst = 1'b0;
      #1;
      check("mid_rst_valid", 512'(sram_wr_valid), 512'(1'b0));
      check("mid_rst_tag", 512'(sram_wr_tag), 512'(5'd0));
      check("mid_rst_data", sram_wr_data, 512'd0);
      check("mid_rst_stall", 512'(dram_rsp_stall), 512'(1'b0));
      @(negedge clk);
      n_rst = 1'b1;
      tick();
      sram_wr_ready = 1'b1;
      for (int k = 0; k < 4; k++) send_beat(5'd11, 3'(k));
      check("post_rst_half_valid", 512'(sram_wr_valid), 512'(1'b0));
      for (int k = 4; k < 8; k++) send_beat(5'd11, 3'(k));
      check("post_rst_valid", 512'(sram_wr_valid), 512'(1'b1));
      check("post_rst_tag", 512'(sram_wr_tag), 512'(5'd11));
      check("post_rst_data", sram_wr_data, exp_row(5'd11));
      tick();

      // transaction end: three rows with cfg_last_row = 2, counter from reset
      n_rst = 1'b0;
      #1;
      n_rst = 1'b1;
      cfg_last_row = 8'd2;
      tick();
      for (int r = 0; r < 3; r++) begin
         fill_row(5'(12 + r), 1'b1, $sformatf("txn_row%0d", r));
         sram_wr_ready = 1'b1;
         #1;
         check($sformatf("txn_done_hs%0d", r), 512'(txn_done), 512'(r == 2));
         tick();
         check($sformatf("txn_after_valid%0d", r), 512'(sram_wr_valid), 512'(1'b0));
         check($sformatf("txn_after_done%0d", r), 512'(txn_done), 512'(1'b0));
         check($sformatf("txn_cnt%0d", r), 512'(dut.row_cnt_r), 512'((r + 1) % 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
